dafx_channel_mixer: RTL and testbench

DAFX_CHANNEL_MIXER -- requirements
Module: dafx_channel_mixer

---
 rtl/dafx_pkg.sv | 16 +
 rtl/dafx_mixer_saturate.sv | 26 ++
 rtl/dafx_channel_mixer.sv | 168 ++++++++++++++++
 tb/tb_dafx_channel_mixer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dafx_pkg.sv
// Shared constants for the DAFX audio blocks: default widths, mixer FSM encodings.
package dafx_pkg;

    localparam int unsigned NR_OF_CHANNELS_C       = 3;
    localparam int unsigned AUDIO_WIDTH_C          = 24;
    localparam int unsigned GAIN_WIDTH_C           = 24;
    localparam int unsigned Q_BITS_C               = 11;
    localparam int unsigned MIXER_CLIP_CNT_WIDTH_C = 16;

    localparam logic [2:0] MIX_IDLE   = 3'd0;
    localparam logic [2:0] MIX_MAC    = 3'd1;
    localparam logic [2:0] MIX_MASTER = 3'd2;
    localparam logic [2:0] MIX_SAT    = 3'd3;
    localparam logic [2:0] MIX_OUT    = 3'd4;

endpackage

// File: rtl/dafx_mixer_saturate.sv
// Combinational signed clamp from IN_WIDTH_P down to OUT_WIDTH_P bits.
module dafx_mixer_saturate #(
    parameter int unsigned IN_WIDTH_P  = 74,
    parameter int unsigned OUT_WIDTH_P = 24
) (
    input  logic signed [IN_WIDTH_P-1:0]  din_i,
    output logic signed [OUT_WIDTH_P-1:0] dout_o,
    output logic                          clip_o
);

    logic [IN_WIDTH_P-OUT_WIDTH_P:0] upper;

    always_comb begin
        // Value fits iff all bits from the output sign bit upward agree.
        upper  = din_i[IN_WIDTH_P-1:OUT_WIDTH_P-1];
        clip_o = (upper != '0) && (upper != '1);
        if (!clip_o) begin
            dout_o = din_i[OUT_WIDTH_P-1:0];
        end else if (din_i[IN_WIDTH_P-1]) begin
            dout_o = {1'b1, {(OUT_WIDTH_P-1){1'b0}}};
        end else begin
            dout_o = {1'b0, {(OUT_WIDTH_P-1){1'b1}}};
        end
    end

endmodule

// File: rtl/dafx_channel_mixer.sv
// N-channel gain mixer: serial MAC over channels, master gain, then saturate.
// One multiplier serves both the per-channel MAC and the master-gain step.
module dafx_channel_mixer
    import dafx_pkg::*;
#(
    parameter int unsigned NR_OF_CHANNELS_P = NR_OF_CHANNELS_C,
    parameter int unsigned AUDIO_WIDTH_P    = AUDIO_WIDTH_C,
    parameter int unsigned GAIN_WIDTH_P     = GAIN_WIDTH_C,
    parameter int unsigned Q_BITS_P         = Q_BITS_C
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       x_valid,
    output logic                                       x_ready,
    input  logic [NR_OF_CHANNELS_P*AUDIO_WIDTH_P-1:0]  x_data,
    input  logic [NR_OF_CHANNELS_P*GAIN_WIDTH_P-1:0]   cr_channel_gain,
    input  logic [GAIN_WIDTH_P-1:0]                    cr_master_gain,
    output logic                                       y_valid,
    input  logic                                       y_ready,
    output logic [AUDIO_WIDTH_P-1:0]                   y_data,
    input  logic                                       cmd_clear_clip,
    output logic [MIXER_CLIP_CNT_WIDTH_C-1:0]          sr_clip_count
);

    localparam int unsigned ACC_W  = AUDIO_WIDTH_P + GAIN_WIDTH_P + $clog2(NR_OF_CHANNELS_P);
    localparam int unsigned PROD_W = ACC_W + GAIN_WIDTH_P;
    localparam int unsigned IDX_W  = (NR_OF_CHANNELS_P > 1) ? $clog2(NR_OF_CHANNELS_P) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_OF_CHANNELS_P - 1);

    logic [2:0]                                 state_q, state_d;
    logic                                       run_q;
    logic [NR_OF_CHANNELS_P*AUDIO_WIDTH_P-1:0]  x_q, x_d;
    logic [NR_OF_CHANNELS_P*GAIN_WIDTH_P-1:0]   gain_q, gain_d;
    logic signed [GAIN_WIDTH_P-1:0]             master_q, master_d;
    logic signed [ACC_W-1:0]                    acc_q, acc_d;
    logic [IDX_W-1:0]                           idx_q, idx_d;
    logic signed [PROD_W-1:0]                   m_q, m_d;
    logic [AUDIO_WIDTH_P-1:0]                   y_q, y_d;
    logic [MIXER_CLIP_CNT_WIDTH_C-1:0]          clip_cnt_q, clip_cnt_d;

    logic signed [AUDIO_WIDTH_P-1:0] x_sel;
    logic signed [GAIN_WIDTH_P-1:0]  g_sel;
    logic signed [ACC_W-1:0]         mul_a;
    logic signed [GAIN_WIDTH_P-1:0]  mul_b;
    logic signed [PROD_W-1:0]        prod;
    logic signed [PROD_W-1:0]        m_shr;
    logic signed [AUDIO_WIDTH_P-1:0] sat_out;
    logic                            sat_clip;

    always_comb begin
        x_sel = '0;
        g_sel = '0;
        for (int i = 0; i < int'(NR_OF_CHANNELS_P); i++) begin
            if (idx_q == IDX_W'(i)) begin
                x_sel = x_q[i*AUDIO_WIDTH_P +: AUDIO_WIDTH_P];
                g_sel = gain_q[i*GAIN_WIDTH_P +: GAIN_WIDTH_P];
            end
        end
    end

    always_comb begin
        if (state_q == MIX_MASTER) begin
            mul_a = acc_q >>> Q_BITS_P;
            mul_b = master_q;
        end else begin
            mul_a = {{(ACC_W-AUDIO_WIDTH_P){x_sel[AUDIO_WIDTH_P-1]}}, x_sel};
            mul_b = g_sel;
        end
        prod  = mul_a * mul_b;
        m_shr = m_q >>> Q_BITS_P;
    end

    dafx_mixer_saturate #(
        .IN_WIDTH_P  (PROD_W),
        .OUT_WIDTH_P (AUDIO_WIDTH_P)
    ) u_saturate (
        .din_i  (m_shr),
        .dout_o (sat_out),
        .clip_o (sat_clip)
    );

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        gain_d     = gain_q;
        master_d   = master_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        m_d        = m_q;
        y_d        = y_q;
        clip_cnt_d = clip_cnt_q;

        case (state_q)
            MIX_IDLE: begin
                if (x_valid && x_ready) begin
                    x_d      = x_data;
                    gain_d   = cr_channel_gain;
                    master_d = cr_master_gain;
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = MIX_MAC;
                end
            end
            MIX_MAC: begin
                acc_d = acc_q + $signed(prod[ACC_W-1:0]);
                if (idx_q == LAST_IDX) begin
                    state_d = MIX_MASTER;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            MIX_MASTER: begin
                m_d     = prod;
                state_d = MIX_SAT;
            end
            MIX_SAT: begin
                y_d = sat_out;
                if (sat_clip && clip_cnt_q != '1) begin
                    clip_cnt_d = clip_cnt_q + 1'b1;
                end
                state_d = MIX_OUT;
            end
            MIX_OUT: begin
                if (y_ready) begin
                    state_d = MIX_IDLE;
                end
            end
            default: state_d = MIX_IDLE;
        endcase

        if (cmd_clear_clip) begin
            clip_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MIX_IDLE;
            run_q      <= 1'b0;
            x_q        <= '0;
            gain_q     <= '0;
            master_q   <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            m_q        <= '0;
            y_q        <= '0;
            clip_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            x_q        <= x_d;
            gain_q     <= gain_d;
            master_q   <= master_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            m_q        <= m_d;
            y_q        <= y_d;
            clip_cnt_q <= clip_cnt_d;
        end
    end

    // run_q holds x_ready low until the first edge after reset release.
    assign x_ready       = run_q && (state_q == MIX_IDLE);
    assign y_valid       = (state_q == MIX_OUT);
    assign y_data        = y_q;
    assign sr_clip_count = clip_cnt_q;

endmodule

// File: tb/tb_dafx_channel_mixer.sv
// Directed self-checking bench for dafx_channel_mixer at default parameters.
module tb_dafx_channel_mixer;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               x_valid = 1'b0;
    logic               x_ready;
    logic [71:0]        x_data = '0;
    logic [71:0]        cr_channel_gain = '0;
    logic [23:0]        cr_master_gain = '0;
    logic               y_valid;
    logic               y_ready = 1'b1;
    logic signed [23:0] y_data;
    logic               cmd_clear_clip = 1'b0;
    logic [15:0]        sr_clip_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic signed [23:0] MAXV = 24'sd8388607;
    localparam logic signed [23:0] MINV = -24'sd8388608;
    localparam logic signed [23:0] UNITY = 24'sd2048;

    always #5 clk = ~clk;

    dafx_channel_mixer u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .x_valid         (x_valid),
        .x_ready         (x_ready),
        .x_data          (x_data),
        .cr_channel_gain (cr_channel_gain),
        .cr_master_gain  (cr_master_gain),
        .y_valid         (y_valid),
        .y_ready         (y_ready),
        .y_data          (y_data),
        .cmd_clear_clip  (cmd_clear_clip),
        .sr_clip_count   (sr_clip_count)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt,
                 total_cnt);
        $fatal(1);
    end

    // Drive a sample set and return #1 after the accepting edge (start of cycle 1).
    task automatic send(input logic signed [23:0] a0, a1, a2, g0, g1, g2, m);
        @(negedge clk);
        x_data          = {a2, a1, a0};
        cr_channel_gain = {g2, g1, g0};
        cr_master_gain  = m;
        x_valid         = 1'b1;
        for (int i = 0; i < 40 && !x_ready; i++) @(negedge clk);
        if (!x_ready) begin
            total_cnt++;
            $display("FAIL send_ready: x_ready=%b, required 1 within 40 cycles", x_ready);
        end
        @(posedge clk);
        #1;
        x_valid = 1'b0;
    endtask

    // Cycle index relative to the handshake cycle (cycle 0) where y_valid is first seen.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!y_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_out();
        y_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({x_ready, y_valid} !== 2'b00)
            $display("FAIL reset_hs: x_ready,y_valid=%b, required 00", {x_ready, y_valid});
        else pass_cnt++;
        total_cnt++;
        if (y_data !== 24'sd0) $display("FAIL reset_y: y_data=%0d, required 0", y_data);
        else pass_cnt++;
        total_cnt++;
        if (sr_clip_count !== 16'd0)
            $display("FAIL reset_clip: clip=%0d, required 0", sr_clip_count);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (x_ready !== 1'b0)
            $display("FAIL release_pre_edge: x_ready=%b, required 0", x_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (x_ready !== 1'b1)
            $display("FAIL release_first_edge: x_ready=%b, required 1", x_ready);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        int lat;
        send(24'sd1000, 24'sd2000, -24'sd500, UNITY, UNITY, UNITY, UNITY);
        wait_out(lat);
        total_cnt++;
        if (lat !== 6 || y_valid !== 1'b1)
            $display("FAIL basic_latency: lat=%0d y_valid=%b, required 6 and 1", lat, y_valid);
        else pass_cnt++;
        total_cnt++;
        if (y_data !== 24'sd2500) $display("FAIL basic_data: y_data=%0d, required 2500", y_data);
        else pass_cnt++;
        total_cnt++;
        if (sr_clip_count !== 16'd0)
            $display("FAIL basic_clip: clip=%0d, required 0", sr_clip_count);
        else pass_cnt++;
        finish_out();
    endtask

    task automatic test_clip();
        int lat;
        send(MAXV, MAXV, MAXV, UNITY, UNITY, UNITY, UNITY);
        wait_out(lat);
        total_cnt++;
        if (y_data !== MAXV || sr_clip_count !== 16'd1)
            $display("FAIL clip_pos: y=%0d clip=%0d, required 8388607 and 1", y_data,
                     sr_clip_count);
        else pass_cnt++;
        finish_out();

        send(MINV, MINV, MINV, UNITY, UNITY, UNITY, UNITY);
        wait_out(lat);
        total_cnt++;
        if (y_data !== MINV || sr_clip_count !== 16'd2)
            $display("FAIL clip_neg: y=%0d clip=%0d, required -8388608 and 2", y_data,
                     sr_clip_count);
        else pass_cnt++;
        finish_out();

        // Clear pulse lands in the SAT cycle (cycle 5) of a clipping sample.
        send(MAXV, MAXV, MAXV, UNITY, UNITY, UNITY, UNITY);
        repeat (4) @(posedge clk);
        #1;
        cmd_clear_clip = 1'b1;
        @(posedge clk);
        #1;
        cmd_clear_clip = 1'b0;
        total_cnt++;
        if (y_valid !== 1'b1 || sr_clip_count !== 16'd0)
            $display("FAIL clip_clear_wins: y_valid=%b clip=%0d, required 1 and 0", y_valid,
                     sr_clip_count);
        else pass_cnt++;
        finish_out();

        send(MINV, MINV, MINV, UNITY, UNITY, UNITY, UNITY);
        wait_out(lat);
        finish_out();
        total_cnt++;
        if (sr_clip_count !== 16'd1)
            $display("FAIL clip_recount: clip=%0d, required 1", sr_clip_count);
        else pass_cnt++;
        @(negedge clk);
        cmd_clear_clip = 1'b1;
        @(posedge clk);
        #1;
        cmd_clear_clip = 1'b0;
        total_cnt++;
        if (sr_clip_count !== 16'd0)
            $display("FAIL clip_clear: clip=%0d, required 0", sr_clip_count);
        else pass_cnt++;
    endtask

    task automatic test_rounding();
        int lat;
        send(24'sd3, 24'sd0, 24'sd0, 24'sd1024, UNITY, UNITY, UNITY);
        wait_out(lat);
        total_cnt++;
        if (y_data !== 24'sd1) $display("FAIL round_pos: y_data=%0d, required 1", y_data);
        else pass_cnt++;
        finish_out();
        send(-24'sd3, 24'sd0, 24'sd0, 24'sd1024, UNITY, UNITY, UNITY);
        wait_out(lat);
        total_cnt++;
        if (y_data !== -24'sd2) $display("FAIL round_neg: y_data=%0d, required -2", y_data);
        else pass_cnt++;
        finish_out();
    endtask

    task automatic test_backpressure();
        int lat;
        y_ready = 1'b0;
        send(24'sd1000, 24'sd2000, -24'sd500, UNITY, UNITY, UNITY, UNITY);
        wait_out(lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (y_valid !== 1'b1 || x_ready !== 1'b0 || y_data !== 24'sd2500)
                $display("FAIL hold_%0d: y_valid=%b x_ready=%b y=%0d, required 1 0 2500", i,
                         y_valid, x_ready, y_data);
            else pass_cnt++;
        end
        finish_out();
        total_cnt++;
        if (x_ready !== 1'b1 || y_valid !== 1'b0)
            $display("FAIL hold_release: x_ready=%b y_valid=%b, required 1 0", x_ready, y_valid);
        else pass_cnt++;
    endtask

    task automatic test_gain_snapshot();
        int lat;
        send(24'sd100, 24'sd200, 24'sd300, UNITY, UNITY, UNITY, UNITY);
        cr_channel_gain = '0;
        cr_master_gain  = 24'sd4096;
        wait_out(lat);
        total_cnt++;
        if (y_data !== 24'sd600) $display("FAIL snapshot: y_data=%0d, required 600", y_data);
        else pass_cnt++;
        finish_out();
    endtask

    task automatic test_reset_mid();
        int lat;
        bit seen;
        send(MAXV, MAXV, MAXV, UNITY, UNITY, UNITY, UNITY);
        wait_out(lat);
        finish_out();
        total_cnt++;
        if (sr_clip_count !== 16'd1)
            $display("FAIL pre_reset_clip: clip=%0d, required 1", sr_clip_count);
        else pass_cnt++;
        send(MAXV, MAXV, MAXV, UNITY, UNITY, UNITY, UNITY);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (x_ready !== 1'b0 || sr_clip_count !== 16'd0 || y_valid !== 1'b0)
            $display("FAIL mid_reset: x_ready=%b clip=%0d y_valid=%b, required 0 0 0", x_ready,
                     sr_clip_count, y_valid);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (y_valid) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0 || sr_clip_count !== 16'd0)
            $display("FAIL mid_reset_drop: y_valid_seen=%b clip=%0d, required 0 0", seen,
                     sr_clip_count);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clip();
        test_rounding();
        test_backpressure();
        test_gain_snapshot();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
